rast_sample_iter: RTL and testbench

- Sample iterator stage of the rasterizer; sits directly downstream of the bounding-box stage and upstream of the hash / sample-test stages.
- Accepts one micropolygon per handshake, together with its grid-aligned bounding box and subsample step.
- Walks every sample position inside the box in raster order, emitting one sample per handshake with the polygon attributes attached.

---
 rtl/rast_sample_iter.sv | 112 +++++++++++
 tb/tb_rast_sample_iter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rast_sample_iter.sv
// Sample iterator: accepts one micropolygon with its snapped bounding box and
// walks every subsample position inside the box in raster order.
module rast_sample_iter #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tri_valid_i,
    output logic                          tri_ready_o,
    input  logic [VERTS*AXIS*SIGFIG-1:0]  tri_i,
    input  logic [COLORS*SIGFIG-1:0]      color_i,
    input  logic [SIGFIG-1:0]             box_ll_x_i,
    input  logic [SIGFIG-1:0]             box_ll_y_i,
    input  logic [SIGFIG-1:0]             box_ur_x_i,
    input  logic [SIGFIG-1:0]             box_ur_y_i,
    input  logic [3:0]                    ss_step_i,
    output logic                          samp_valid_o,
    input  logic                          samp_ready_i,
    output logic [VERTS*AXIS*SIGFIG-1:0]  samp_tri_o,
    output logic [COLORS*SIGFIG-1:0]      samp_color_o,
    output logic [SIGFIG-1:0]             samp_x_o,
    output logic [SIGFIG-1:0]             samp_y_o,
    output logic                          samp_last_o,
    output logic                          busy_o
);

    typedef enum logic {IDLE, WALK} state_t;

    state_t state, state_nxt;

    logic [VERTS*AXIS*SIGFIG-1:0] tri_q;
    logic [COLORS*SIGFIG-1:0]     color_q;
    logic [SIGFIG-1:0]            ll_x_q, ur_x_q, ur_y_q, step_q, x_q, y_q;
    logic [SIGFIG-1:0]            step_dec;
    logic [SIGFIG:0]              nx, ny;
    logic                         x_wrap, y_end, accept, adv;

    always_comb begin
        case (ss_step_i)
            4'b0100: step_dec = SIGFIG'(1) << (RADIX - 1);
            4'b0010: step_dec = SIGFIG'(1) << (RADIX - 2);
            4'b0001: step_dec = SIGFIG'(1) << (RADIX - 3);
            default: step_dec = SIGFIG'(1) << RADIX;
        endcase
    end

    // One extra bit so a step past the top of the signed range cannot wrap.
    assign nx     = {x_q[SIGFIG-1], x_q} + {step_q[SIGFIG-1], step_q};
    assign ny     = {y_q[SIGFIG-1], y_q} + {step_q[SIGFIG-1], step_q};
    assign x_wrap = $signed(nx) > $signed({ur_x_q[SIGFIG-1], ur_x_q});
    assign y_end  = $signed(ny) > $signed({ur_y_q[SIGFIG-1], ur_y_q});

    assign tri_ready_o = rst_n && (state == IDLE);
    assign accept      = tri_valid_i && tri_ready_o;
    assign adv         = (state == WALK) && samp_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = WALK;
            WALK: if (adv && x_wrap && y_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tri_q   <= '0;
            color_q <= '0;
            ll_x_q  <= '0;
            ur_x_q  <= '0;
            ur_y_q  <= '0;
            step_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (accept) begin
            tri_q   <= tri_i;
            color_q <= color_i;
            ll_x_q  <= box_ll_x_i;
            ur_x_q  <= box_ur_x_i;
            ur_y_q  <= box_ur_y_i;
            step_q  <= step_dec;
            x_q     <= box_ll_x_i;
            y_q     <= box_ll_y_i;
        end else if (adv) begin
            if (!x_wrap) begin
                x_q <= nx[SIGFIG-1:0];
            end else begin
                x_q <= ll_x_q;
                y_q <= ny[SIGFIG-1:0];
            end
        end
    end

    assign samp_valid_o = (state == WALK);
    assign busy_o       = (state == WALK);
    assign samp_last_o  = (state == WALK) && x_wrap && y_end;
    assign samp_tri_o   = tri_q;
    assign samp_color_o = color_q;
    assign samp_x_o     = x_q;
    assign samp_y_o     = y_q;

endmodule

// File: tb/tb_rast_sample_iter.sv
// Scoreboard bench for rast_sample_iter: expected samples are queued when a
// polygon is driven and popped by a monitor on every sample handshake.
module tb_rast_sample_iter;

    localparam int S  = 24;
    localparam int TW = 3 * 3 * S;
    localparam int CW = 3 * S;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tri_valid_i;
    logic          tri_ready_o;
    logic [TW-1:0] tri_i;
    logic [CW-1:0] color_i;
    logic [S-1:0]  box_ll_x_i, box_ll_y_i, box_ur_x_i, box_ur_y_i;
    logic [3:0]    ss_step_i;
    logic          samp_valid_o;
    logic          samp_ready_i;
    logic [TW-1:0] samp_tri_o;
    logic [CW-1:0] samp_color_o;
    logic [S-1:0]  samp_x_o, samp_y_o;
    logic          samp_last_o;
    logic          busy_o;

    rast_sample_iter #(.SIGFIG(24), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .tri_valid_i(tri_valid_i), .tri_ready_o(tri_ready_o),
        .tri_i(tri_i), .color_i(color_i),
        .box_ll_x_i(box_ll_x_i), .box_ll_y_i(box_ll_y_i),
        .box_ur_x_i(box_ur_x_i), .box_ur_y_i(box_ur_y_i),
        .ss_step_i(ss_step_i),
        .samp_valid_o(samp_valid_o), .samp_ready_i(samp_ready_i),
        .samp_tri_o(samp_tri_o), .samp_color_o(samp_color_o),
        .samp_x_o(samp_x_o), .samp_y_o(samp_y_o),
        .samp_last_o(samp_last_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [S-1:0]  x;
        logic [S-1:0]  y;
        logic          last;
        logic [TW-1:0] tri_v;
        logic [CW-1:0] col;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_count = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && samp_valid_o === 1'b1 && samp_ready_i === 1'b1) begin
            hs_count++;
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_sample: got x=%h y=%h, required no sample", samp_x_o, samp_y_o);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (samp_x_o !== e.x) begin n_fail++; $display("FAIL samp_x: got %h, required %h", samp_x_o, e.x); end
                n_checks++;
                if (samp_y_o !== e.y) begin n_fail++; $display("FAIL samp_y: got %h, required %h", samp_y_o, e.y); end
                n_checks++;
                if (samp_last_o !== e.last) begin n_fail++; $display("FAIL samp_last at (%h,%h): got %b, required %b", e.x, e.y, samp_last_o, e.last); end
                n_checks++;
                if (samp_tri_o !== e.tri_v) begin n_fail++; $display("FAIL samp_tri at (%h,%h): got %h, required %h", e.x, e.y, samp_tri_o, e.tri_v); end
                n_checks++;
                if (samp_color_o !== e.col) begin n_fail++; $display("FAIL samp_color at (%h,%h): got %h, required %h", e.x, e.y, samp_color_o, e.col); end
            end
        end
    end

    // Expected sample list: count from the closed-form formula, last = final index.
    task automatic push_box(input int llx, input int lly, input int urx, input int ury,
                            input int step, input logic [TW-1:0] t, input logic [CW-1:0] c);
        int nxs, nys, idx;
        exp_t e;
        nxs = (urx - llx) / step + 1;
        nys = (ury - lly) / step + 1;
        idx = 0;
        for (int j = 0; j < nys; j++) begin
            for (int i = 0; i < nxs; i++) begin
                e.x     = S'(llx + i * step);
                e.y     = S'(lly + j * step);
                e.last  = (idx == nxs * nys - 1);
                e.tri_v = t;
                e.col   = c;
                sb.push_back(e);
                idx++;
            end
        end
    endtask

    task automatic rand_attr(output logic [TW-1:0] t, output logic [CW-1:0] c);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        t = r[TW-1:0];
        c = r[255 -: CW];
    endtask

    task automatic send_poly(input int llx, input int lly, input int urx, input int ury,
                             input logic [3:0] code, input int step,
                             input logic [TW-1:0] t, input logic [CW-1:0] c,
                             output int waited);
        logic ready_seen, accepted;
        push_box(llx, lly, urx, ury, step, t, c);
        tri_i = t; color_i = c;
        box_ll_x_i = S'(llx); box_ll_y_i = S'(lly);
        box_ur_x_i = S'(urx); box_ur_y_i = S'(ury);
        ss_step_i = code;
        tri_valid_i = 1'b1;
        waited = 0;
        accepted = 1'b0;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            ready_seen = tri_ready_o;
            @(posedge clk); #1;
            waited++;
            accepted = ready_seen;
        end
        tri_valid_i = 1'b0;
        if (!accepted) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", waited);
        end
    endtask

    task automatic wait_drain(output int cycles);
        cycles = 0;
        while (sb.size() != 0 && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (sb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d samples outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tri_valid_i = 1'b0; samp_ready_i = 1'b1;
        tri_i = '0; color_i = '0; ss_step_i = 4'b1000;
        box_ll_x_i = '0; box_ll_y_i = '0; box_ur_x_i = '0; box_ur_y_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (tri_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_tri_ready: got %b, required 0", tri_ready_o); end
        n_checks++;
        if ({samp_valid_o, samp_last_o, busy_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b, required 000", {samp_valid_o, samp_last_o, busy_o}); end
        n_checks++;
        if ({samp_x_o, samp_y_o, samp_tri_o, samp_color_o} !== '0) begin n_fail++; $display("FAIL reset_data: got nonzero data, required 0"); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (tri_ready_o !== 1'b1) begin n_fail++; $display("FAIL release_tri_ready: got %b, required 1", tri_ready_o); end
    endtask

    task automatic test_single();
        logic [TW-1:0] t; logic [CW-1:0] c; int w, cyc;
        rand_attr(t, c);
        send_poly(32'h400, 32'h400, 32'h400, 32'h400, 4'b1000, 1024, t, c, w);
        wait_drain(cyc);
        n_checks++;
        if (cyc !== 1) begin n_fail++; $display("FAIL single_cycles: got %0d, required 1", cyc); end
        n_checks++;
        if (tri_ready_o !== 1'b1 || samp_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_return_idle: got ready=%b valid=%b, required ready=1 valid=0", tri_ready_o, samp_valid_o); end
    endtask

    task automatic test_walk3x3();
        logic [TW-1:0] t; logic [CW-1:0] c; int w, cyc;
        rand_attr(t, c);
        send_poly(0, 0, 32'h400, 32'h400, 4'b0100, 512, t, c, w);
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL walk_busy: got %b, required 1", busy_o); end
        wait_drain(cyc);
        n_checks++;
        if (cyc !== 9) begin n_fail++; $display("FAIL walk_throughput: got %0d cycles, required 9", cyc); end
        n_checks++;
        if (tri_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL walk_return_idle: got ready=%b busy=%b, required 1 0", tri_ready_o, busy_o); end
    endtask

    task automatic test_backpressure();
        logic [TW-1:0] t; logic [CW-1:0] c; int w, cyc, base, guard;
        rand_attr(t, c);
        base = hs_count;
        send_poly(0, 0, 32'h400, 32'h400, 4'b0100, 512, t, c, w);
        guard = 0;
        while (hs_count - base < 3 && guard < 50) begin @(posedge clk); #1; guard++; end
        samp_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (samp_valid_o !== 1'b1 || samp_x_o !== 24'h0 || samp_y_o !== 24'h200 || samp_last_o !== 1'b0 || samp_tri_o !== t) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got v=%b x=%h y=%h last=%b, required v=1 x=000000 y=000200 last=0", k, samp_valid_o, samp_x_o, samp_y_o, samp_last_o);
            end
        end
        @(posedge clk); #1;
        samp_ready_i = 1'b1;
        wait_drain(cyc);
        n_checks++;
        if (hs_count - base !== 9) begin n_fail++; $display("FAIL bp_handshakes: got %0d, required 9", hs_count - base); end
    endtask

    task automatic test_negative();
        logic [TW-1:0] t; logic [CW-1:0] c; int w, cyc;
        rand_attr(t, c);
        send_poly(-1024, -1024, 0, -1024, 4'b1000, 1024, t, c, w);
        wait_drain(cyc);
        n_checks++;
        if (cyc !== 2) begin n_fail++; $display("FAIL neg_count: got %0d cycles, required 2", cyc); end
    endtask

    task automatic test_step_codes();
        logic [TW-1:0] t; logic [CW-1:0] c; int w, cyc;
        rand_attr(t, c);
        send_poly(0, 0, 32'h80, 32'h80, 4'b0001, 128, t, c, w);
        wait_drain(cyc);
        n_checks++;
        if (cyc !== 4) begin n_fail++; $display("FAIL step_eighth_count: got %0d, required 4", cyc); end
        @(posedge clk); #1;
        rand_attr(t, c);
        send_poly(32'h400, 0, 32'h800, 32'h100, 4'b0110, 1024, t, c, w);
        wait_drain(cyc);
        n_checks++;
        if (cyc !== 2) begin n_fail++; $display("FAIL step_invalid_count: got %0d, required 2", cyc); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] ta, tb; logic [CW-1:0] ca, cb; int w, cyc;
        rand_attr(ta, ca);
        rand_attr(tb, cb);
        send_poly(0, 0, 32'h400, 32'h400, 4'b0100, 512, ta, ca, w);
        send_poly(32'h800, 32'h800, 32'hC00, 32'h800, 4'b1000, 1024, tb, cb, w);
        n_checks++;
        if (w !== 10) begin n_fail++; $display("FAIL busy_accept_delay: got %0d cycles, required 10", w); end
        n_checks++;
        if (samp_valid_o !== 1'b1 || samp_x_o !== 24'h800 || samp_y_o !== 24'h800) begin
            n_fail++; $display("FAIL busy_first_sample: got v=%b x=%h y=%h, required v=1 x=000800 y=000800", samp_valid_o, samp_x_o, samp_y_o);
        end
        wait_drain(cyc);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [TW-1:0] t; logic [CW-1:0] c; int w, cyc, base, guard;
        rand_attr(t, c);
        base = hs_count;
        send_poly(0, 0, 32'h400, 32'h400, 4'b0100, 512, t, c, w);
        guard = 0;
        while (hs_count - base < 2 && guard < 50) begin @(posedge clk); #1; guard++; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (samp_valid_o !== 1'b0 || busy_o !== 1'b0 || tri_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state: got v=%b busy=%b ready=%b, required 0 0 0", samp_valid_o, busy_o, tri_ready_o);
        end
        rst_n = 1'b1;
        sb.delete();
        #1;
        n_checks++;
        if (tri_ready_o !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b, required 1", tri_ready_o); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (samp_valid_o !== 1'b0) begin n_fail++; $display("FAIL midreset_stale cycle %0d: got valid=%b, required 0", k, samp_valid_o); end
        end
        @(posedge clk); #1;
        rand_attr(t, c);
        send_poly(32'h800, 32'hC00, 32'h900, 32'hC00, 4'b0010, 256, t, c, w);
        wait_drain(cyc);
        n_checks++;
        if (cyc !== 2) begin n_fail++; $display("FAIL midreset_new_walk: got %0d cycles, required 2", cyc); end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_single();
        @(posedge clk); #1;
        test_walk3x3();
        @(posedge clk); #1;
        test_backpressure();
        @(posedge clk); #1;
        test_negative();
        @(posedge clk); #1;
        test_step_codes();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
